tipi_ti_reg_port: RTL
=====================

Name: tipi_ti_reg_port

Overview:
- TI-99/4A-side register port for the TIPI card.
- Synchronises the asynchronous TI expansion-bus strobes into the clk domain and decodes the four TIPI mailbox addresses.
- Latches the TD/TC bytes written by the TI and presents the RD/RC bytes for TI reads.
- Sits directly upstream of the 4-bit Pi nibble bus block: feeds it TD/TC and consumes its RD/RC.

Parameters:
ADDR_TC, 16'h5FFF, TI address of TI->Pi control byte (write)
ADDR_TD, 16'h5FFD, TI address of TI->Pi data byte (write)
ADDR_RC, 16'h5FFB, TI address of Pi->TI control byte (read)
ADDR_RD, 16'h5FF9, TI address of Pi->TI data byte (read)
SYNC_STAGES, 2, flip-flop stages on each async strobe (min 2)
MIN_STROBE, 2, synced clk cycles a strobe must stay active before it is accepted (glitch filter)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
card_en  in  1  CRU enable bit; 0 = port ignores TI accesses
ti_memen_n  in  1  TI memory enable, active low, async
ti_we_n  in  1  TI write strobe, active low, async
ti_dbin  in  1  TI read strobe, active high, async
ti_a  in  16  TI address, async, stable while strobe active
ti_d_in  in  8  TI write data, async, stable while ti_we_n low
ti_d_out  out  8  read data to TI bus transceiver
ti_d_oe  out  1  drive enable for ti_d_out
TD  out  8  TI->Pi data byte
TC  out  8  TI->Pi control byte
RD  in  8  Pi->TI data byte
RC  in  8  Pi->TI control byte
td_wr  out  1  one-cycle pulse when TD is updated
tc_wr  out  1  one-cycle pulse when TC is updated
rc_rd  out  1  one-cycle pulse at completion of a TI read of RC

Behaviour:
- Reset values: TD=0, TC=0, td_wr=tc_wr=rc_rd=0, ti_d_out=0, snapshot regs=0, all sync FFs hold the inactive level (we_n=1, memen_n=1, dbin=0), FSM=IDLE.
- Strobes ti_we_n, ti_memen_n, ti_dbin each pass through SYNC_STAGES FFs.
- Synced write access: we_s=0 and memen_s=0. Synced read access: dbin_s=1 and memen_s=0.
- FSM has five states: IDLE, WR_ARM, WR_HOLD, RD_HOLD, WAIT_IDLE.
- IDLE:
  - Synced write access, card_en=1 -> WR_ARM, counter cleared.
  - Synced read access, card_en=1, ti_a==ADDR_RD or ADDR_RC -> RD_HOLD.
  - Any other access -> stays in IDLE.
- WR_ARM:
  - Count cycles while the write access persists.
  - When the count reaches MIN_STROBE, capture ti_a and ti_d_in into hold registers and go to WR_HOLD.
  - If the strobe deasserts first (glitch) -> IDLE with no effect.
- WR_HOLD:
  - Held until we_s returns to 1, then commit.
  - Commit: if the held address is ADDR_TD, TD<=data and td_wr=1 for one cycle; if ADDR_TC, TC<=data and tc_wr=1.
  - Any other held address is ignored silently. Next state is IDLE.
  - Write latency: TD/TC and pulse are visible SYNC_STAGES+1 cycles after raw ti_we_n rises.
- Read snapshot:
  - RD/RC are copied into snapshot registers every cycle while in IDLE.
  - The snapshot is frozen in RD_HOLD, so a Pi update mid-read cannot tear the byte.
  - ti_d_out = snapshot of RC when ti_a==ADDR_RC, snapshot of RD when ti_a==ADDR_RD, else 0.
- ti_d_oe (combinational, from raw inputs): ti_d_oe = card_en & ~ti_memen_n & ti_dbin & (ti_a==ADDR_RD | ti_a==ADDR_RC). It carries no sync latency, to meet TI bus access timing.
- RD_HOLD: exits to IDLE when dbin_s=0. If the captured address was ADDR_RC, rc_rd pulses one cycle on exit.
- Writes to ADDR_RD/ADDR_RC and reads of ADDR_TD/ADDR_TC have no effect and ti_d_oe stays 0.
- card_en dropping mid-access:
  - WR_HOLD finishes without commit.
  - RD_HOLD finishes without the rc_rd pulse.
  - ti_d_oe drops immediately.
- Reset mid-access:
  - FSM -> WAIT_IDLE after reset release if any synced strobe is still active.
  - WAIT_IDLE leaves for IDLE only once we_s=1, dbin_s=0 and memen_s=1 are seen together; no partial commit occurs.
- Simultaneous we_s and dbin_s active: write takes priority; the read is ignored for that access.
- Back-to-back writes: each requires a full we_n deassert between accesses; rewriting the same value still produces a pulse.

Test Plan:
- Write 8'hA5 to 16'h5FFD with 3-cycle-wide we_n low, card_en=1 -> TD=8'hA5, single td_wr pulse 3 cycles after we_n rises, TC unchanged at 0.
- Write 8'h3C to 16'h5FFF, then 1-cycle we_n glitch carrying 8'hFF to 16'h5FFF -> TC=8'h3C, exactly one tc_wr pulse.
- RC=8'h81; TI read of 16'h5FFB; RC changes to 8'h42 mid-read -> ti_d_oe=1 during read, ti_d_out stays 8'h81, one rc_rd pulse after dbin falls; next read returns 8'h42.
- card_en=0, write 8'h11 to 16'h5FFD and read 16'h5FF9 -> TD unchanged, no pulses, ti_d_oe=0 throughout.
- Assert reset while we_n low with data 8'h77 to 16'h5FFD, release before we_n rises -> TD=0, no td_wr; next clean write of 8'h12 -> TD=8'h12.

Source files
------------

// File: rtl/tipi_ti_reg_port.sv
// TI-99/4A expansion-bus register port for TIPI: synchronises the TI strobes,
// latches TD/TC writes and serves tear-free RD/RC reads.
module tipi_ti_reg_port #(
    parameter logic [15:0] ADDR_TC     = 16'h5FFF,
    parameter logic [15:0] ADDR_TD     = 16'h5FFD,
    parameter logic [15:0] ADDR_RC     = 16'h5FFB,
    parameter logic [15:0] ADDR_RD     = 16'h5FF9,
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_STROBE  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_en,
    input  logic        ti_memen_n,
    input  logic        ti_we_n,
    input  logic        ti_dbin,
    input  logic [15:0] ti_a,
    input  logic [7:0]  ti_d_in,
    output logic [7:0]  ti_d_out,
    output logic        ti_d_oe,
    output logic [7:0]  TD,
    output logic [7:0]  TC,
    input  logic [7:0]  RD,
    input  logic [7:0]  RC,
    output logic        td_wr,
    output logic        tc_wr,
    output logic        rc_rd
);
    localparam int CNT_W  = $clog2(MIN_STROBE + 1);
    localparam int INIT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_STROBE);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {IDLE, WR_ARM, WR_HOLD, RD_HOLD, WAIT_IDLE} state_t;

    logic [SYNC_STAGES-1:0] we_sync_reg, memen_sync_reg, dbin_sync_reg;
    logic [INIT_W-1:0]      init_reg;
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   abort_reg, abort_next;
    logic                   rd_is_rc_reg, rd_is_rc_next;
    logic [15:0]            hold_a_reg, hold_a_next;
    logic [7:0]             hold_d_reg, hold_d_next;
    logic [7:0]             td_reg, td_next, tc_reg, tc_next;
    logic                   td_wr_reg, td_wr_next, tc_wr_reg, tc_wr_next;
    logic                   rc_rd_reg, rc_rd_next;
    logic [7:0]             snap_rd_reg, snap_rd_next, snap_rc_reg, snap_rc_next;

    logic we_s, memen_s, dbin_s, wr_acc, rd_acc, strobe_any, starting, rd_addr_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_sync_reg    <= '1;
            memen_sync_reg <= '1;
            dbin_sync_reg  <= '0;
        end else begin
            we_sync_reg    <= {we_sync_reg[SYNC_STAGES-2:0], ti_we_n};
            memen_sync_reg <= {memen_sync_reg[SYNC_STAGES-2:0], ti_memen_n};
            dbin_sync_reg  <= {dbin_sync_reg[SYNC_STAGES-2:0], ti_dbin};
        end
    end

    assign we_s        = we_sync_reg[SYNC_STAGES-1];
    assign memen_s     = memen_sync_reg[SYNC_STAGES-1];
    assign dbin_s      = dbin_sync_reg[SYNC_STAGES-1];
    assign wr_acc      = ~we_s & ~memen_s;
    assign rd_acc      = dbin_s & ~memen_s;
    assign strobe_any  = ~we_s | ~memen_s | dbin_s;
    assign rd_addr_hit = (ti_a == ADDR_RD) | (ti_a == ADDR_RC);
    // The synchronisers need SYNC_STAGES+1 cycles after reset before they show
    // the real bus; an access already in flight then must be waited out.
    assign starting    = (init_reg != '0);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        abort_next    = abort_reg;
        rd_is_rc_next = rd_is_rc_reg;
        hold_a_next   = hold_a_reg;
        hold_d_next   = hold_d_reg;
        td_next       = td_reg;
        tc_next       = tc_reg;
        td_wr_next    = 1'b0;
        tc_wr_next    = 1'b0;
        rc_rd_next    = 1'b0;
        snap_rd_next  = snap_rd_reg;
        snap_rc_next  = snap_rc_reg;
        case (state_reg)
            IDLE: begin
                snap_rd_next = RD;
                snap_rc_next = RC;
                abort_next   = 1'b0;
                if (starting) begin
                    if (strobe_any) state_next = WAIT_IDLE;
                end else if (wr_acc && card_en) begin
                    state_next = WR_ARM;
                    cnt_next   = '0;
                end else if (rd_acc && card_en && rd_addr_hit) begin
                    state_next    = RD_HOLD;
                    rd_is_rc_next = (ti_a == ADDR_RC);
                end
            end
            WR_ARM: begin
                if (!wr_acc || !card_en) begin
                    state_next = IDLE;
                end else if (cnt_reg + 1'b1 == MIN_CNT) begin
                    hold_a_next = ti_a;
                    hold_d_next = ti_d_in;
                    state_next  = WR_HOLD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WR_HOLD: begin
                if (!card_en) abort_next = 1'b1;
                if (we_s) begin
                    state_next = IDLE;
                    if (card_en && !abort_reg) begin
                        if (hold_a_reg == ADDR_TD) begin
                            td_next    = hold_d_reg;
                            td_wr_next = 1'b1;
                        end else if (hold_a_reg == ADDR_TC) begin
                            tc_next    = hold_d_reg;
                            tc_wr_next = 1'b1;
                        end
                    end
                end
            end
            RD_HOLD: begin
                if (!card_en) abort_next = 1'b1;
                if (!dbin_s) begin
                    state_next = IDLE;
                    rc_rd_next = rd_is_rc_reg & card_en & ~abort_reg;
                end
            end
            WAIT_IDLE: begin
                if (we_s && !dbin_s && memen_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_reg     <= INIT_LOAD;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            abort_reg    <= 1'b0;
            rd_is_rc_reg <= 1'b0;
            hold_a_reg   <= '0;
            hold_d_reg   <= '0;
            td_reg       <= '0;
            tc_reg       <= '0;
            td_wr_reg    <= 1'b0;
            tc_wr_reg    <= 1'b0;
            rc_rd_reg    <= 1'b0;
            snap_rd_reg  <= '0;
            snap_rc_reg  <= '0;
        end else begin
            if (starting) init_reg <= init_reg - 1'b1;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            abort_reg    <= abort_next;
            rd_is_rc_reg <= rd_is_rc_next;
            hold_a_reg   <= hold_a_next;
            hold_d_reg   <= hold_d_next;
            td_reg       <= td_next;
            tc_reg       <= tc_next;
            td_wr_reg    <= td_wr_next;
            tc_wr_reg    <= tc_wr_next;
            rc_rd_reg    <= rc_rd_next;
            snap_rd_reg  <= snap_rd_next;
            snap_rc_reg  <= snap_rc_next;
        end
    end

    // Output enable and read mux work from the raw bus so the TI sees data
    // within its access window; only the data source is synchronised.
    assign ti_d_oe = card_en & ~ti_memen_n & ti_dbin & rd_addr_hit;

    always_comb begin
        ti_d_out = '0;
        if (ti_a == ADDR_RC)      ti_d_out = snap_rc_reg;
        else if (ti_a == ADDR_RD) ti_d_out = snap_rd_reg;
    end

    assign TD    = td_reg;
    assign TC    = tc_reg;
    assign td_wr = td_wr_reg;
    assign tc_wr = tc_wr_reg;
    assign rc_rd = rc_rd_reg;
endmodule
